// File: rtl/unsharp_mask_frame_ctrl.sv
// Frame controller around the unsharp_mask kernel: loads a frame into img RAM, runs the
// kernel through ap_ctrl_hs, then streams mask_img out through a 2-entry skid FIFO.
module unsharp_mask_frame_ctrl #(
    parameter int NUM_PIX = 1024,
    parameter int KLEN    = 8
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        go,
    output logic        busy,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    output logic        k_ap_start,
    input  logic        k_ap_done,
    input  logic        k_ap_ready,
    input  logic        k_ap_idle,
    input  logic        img_ce0,
    input  logic        img_we0,
    input  logic [9:0]  img_address0,
    input  logic [31:0] img_d0,
    output logic [31:0] img_q0,
    input  logic        mask_img_ce0,
    input  logic        mask_img_we0,
    input  logic [9:0]  mask_img_address0,
    input  logic [31:0] mask_img_d0,
    output logic [31:0] mask_img_q0,
    input  logic        kernelDataX_ce0,
    input  logic        kernelDataX_we0,
    input  logic [2:0]  kernelDataX_address0,
    input  logic [31:0] kernelDataX_d0,
    output logic [31:0] kernelDataX_q0,
    input  logic        kernelDataY_ce0,
    input  logic        kernelDataY_we0,
    input  logic [2:0]  kernelDataY_address0,
    input  logic [31:0] kernelDataY_d0,
    output logic [31:0] kernelDataY_q0
);

    localparam int          PIX_AW    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int          K_AW      = (KLEN > 1) ? $clog2(KLEN) : 1;
    localparam logic [10:0] NUM_PIX_W = 11'(NUM_PIX);
    localparam logic [9:0]  LAST_ADDR = 10'(NUM_PIX - 1);
    localparam logic [3:0]  KLEN_W    = 4'(KLEN);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [9:0]  wr_cnt_reg;
    logic [9:0]  rd_cnt_reg;
    logic        rd_all_reg;
    logic        rd_pend_reg, rd_pend_last_reg;
    logic [31:0] mask_rd_q;
    logic [1:0]  fifo_cnt_reg;
    logic        fifo_wr_ptr_reg, fifo_rd_ptr_reg;
    logic [31:0] fifo_data_reg [2];
    logic [1:0]  fifo_last_reg;
    logic        in_beat, load_wr, pop, push, issue, run_en, cfg_wr_en;
    logic [2:0]  fifo_used;

    // k_ap_idle carries no information this controller needs
    logic unused_inputs;
    assign unused_inputs = k_ap_idle;

    assign busy       = (state_reg != S_IDLE);
    assign in_ready   = (state_reg == S_LOAD);
    assign k_ap_start = (state_reg == S_START);
    assign in_beat    = in_valid & in_ready;
    assign load_wr    = in_beat & ~ap_rst;
    assign run_en     = (state_reg == S_RUN) & ~ap_rst;
    assign cfg_wr_en  = (state_reg == S_IDLE) & cfg_we;

    assign out_valid  = (fifo_cnt_reg != 2'd0);
    assign out_data   = out_valid ? fifo_data_reg[fifo_rd_ptr_reg] : '0;
    assign out_last   = out_valid & fifo_last_reg[fifo_rd_ptr_reg];
    assign pop        = out_valid & out_ready;
    assign push       = rd_pend_reg;
    // Count this cycle's pop as free space so a steady drain sustains one word per cycle
    assign fifo_used  = {1'b0, fifo_cnt_reg} + {2'b0, rd_pend_reg} - {2'b0, pop};
    assign issue      = (state_reg == S_DRAIN) && !rd_all_reg && (fifo_used < 3'd2);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (go) state_next = S_LOAD;
            S_LOAD:  if (in_beat && wr_cnt_reg == LAST_ADDR) state_next = S_START;
            S_START: if (k_ap_ready) state_next = k_ap_done ? S_DRAIN : S_RUN;
            S_RUN:   if (k_ap_done) state_next = S_DRAIN;
            S_DRAIN: if (pop && out_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
            rd_all_reg <= 1'b0;
        end else begin
            if (state_reg == S_IDLE && go) wr_cnt_reg <= '0;
            else if (in_beat)              wr_cnt_reg <= wr_cnt_reg + 10'd1;
            if (state_reg != S_DRAIN && state_next == S_DRAIN) begin
                rd_cnt_reg <= '0;
                rd_all_reg <= 1'b0;
            end else if (issue) begin
                rd_cnt_reg <= rd_cnt_reg + 10'd1;
                if (rd_cnt_reg == LAST_ADDR) rd_all_reg <= 1'b1;
            end
        end
    end

    // img RAM: stream writes during LOAD, kernel port during RUN
    logic [31:0] img_mem [NUM_PIX];
    logic        img_in_range, img_wr_en;
    logic [PIX_AW-1:0] img_wr_idx;
    logic [31:0] img_wr_data;

    assign img_in_range = ({1'b0, img_address0} < NUM_PIX_W);
    assign img_wr_en    = load_wr | (run_en & img_ce0 & img_we0 & img_in_range);
    assign img_wr_idx   = load_wr ? wr_cnt_reg[PIX_AW-1:0] : img_address0[PIX_AW-1:0];
    assign img_wr_data  = load_wr ? in_data : img_d0;

    always_ff @(posedge ap_clk) begin
        if (img_wr_en) img_mem[img_wr_idx] <= img_wr_data;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst)                  img_q0 <= '0;
        else if (run_en && img_ce0)  img_q0 <= img_in_range ? img_mem[img_address0[PIX_AW-1:0]] : '0;
    end

    // mask RAM: kernel read/write port plus a read-only drain port
    logic [31:0] mask_mem [NUM_PIX];
    logic        mask_in_range;

    assign mask_in_range = ({1'b0, mask_img_address0} < NUM_PIX_W);

    always_ff @(posedge ap_clk) begin
        if (run_en && mask_img_ce0 && mask_img_we0 && mask_in_range)
            mask_mem[mask_img_address0[PIX_AW-1:0]] <= mask_img_d0;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst)                      mask_img_q0 <= '0;
        else if (run_en && mask_img_ce0) mask_img_q0 <= mask_in_range ? mask_mem[mask_img_address0[PIX_AW-1:0]] : '0;
    end

    always_ff @(posedge ap_clk) begin
        if (issue) mask_rd_q <= mask_mem[rd_cnt_reg[PIX_AW-1:0]];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rd_pend_reg      <= 1'b0;
            rd_pend_last_reg <= 1'b0;
            fifo_cnt_reg     <= '0;
            fifo_wr_ptr_reg  <= 1'b0;
            fifo_rd_ptr_reg  <= 1'b0;
            fifo_last_reg    <= '0;
        end else begin
            rd_pend_reg      <= issue;
            rd_pend_last_reg <= issue && (rd_cnt_reg == LAST_ADDR);
            if (push) begin
                fifo_data_reg[fifo_wr_ptr_reg] <= mask_rd_q;
                fifo_last_reg[fifo_wr_ptr_reg] <= rd_pend_last_reg;
                fifo_wr_ptr_reg                <= ~fifo_wr_ptr_reg;
            end
            if (pop) fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
        end
    end

    // Coefficient tables (index 0 = X, 1 = Y): cleared on reset, host-written in IDLE
    logic [1:0]       k_ce, k_we;
    logic [1:0][2:0]  k_addr;
    logic [1:0][31:0] k_d;

    assign k_ce   = {kernelDataY_ce0, kernelDataX_ce0};
    assign k_we   = {kernelDataY_we0, kernelDataX_we0};
    assign k_addr = {kernelDataY_address0, kernelDataX_address0};
    assign k_d    = {kernelDataY_d0, kernelDataX_d0};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_tbl
            logic [31:0] tbl [KLEN];
            logic [31:0] q_reg;
            logic        addr_ok;

            assign addr_ok = ({1'b0, k_addr[gi]} < KLEN_W);

            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    for (int j = 0; j < KLEN; j++) tbl[j] <= '0;
                    q_reg <= '0;
                end else begin
                    for (int j = 0; j < KLEN; j++) begin
                        if (cfg_wr_en && cfg_sel == 1'(gi) && cfg_addr == 3'(j))
                            tbl[j] <= cfg_data;
                        else if (run_en && k_ce[gi] && k_we[gi] && k_addr[gi] == 3'(j))
                            tbl[j] <= k_d[gi];
                    end
                    if (run_en && k_ce[gi])
                        q_reg <= addr_ok ? tbl[k_addr[gi][K_AW-1:0]] : '0;
                end
            end
        end
    endgenerate

    assign kernelDataX_q0 = g_tbl[0].q_reg;
    assign kernelDataY_q0 = g_tbl[1].q_reg;

endmodule

// File: doc/unsharp_mask_frame_ctrl.md
Name: unsharp_mask_frame_ctrl

Overview:
- Frame controller directly upstream and downstream of the unsharp_mask HLS wrapper.
- Owns the backing memories the kernel addresses: img RAM, mask_img RAM, and the kernelDataX/kernelDataY coefficient tables.
- Loads one frame from an input valid/ready stream, launches the kernel via ap_ctrl_hs, waits for ap_done, then streams mask_img out over a valid/ready stream.

Parameters:
- NUM_PIX, 1024, pixels per frame; 1..1024 (img/mask address width is 10).
- KLEN, 8, coefficient entries per kernel table (address width 3).

Ports:
- ap_clk in 1 clock
- ap_rst in 1 synchronous active-high reset
- go in 1 start-of-frame request, sampled in IDLE
- busy out 1 high in any state other than IDLE
- in_valid in 1 / in_ready out 1 / in_data in 32: input pixel stream
- out_valid out 1 / out_ready in 1 / out_data out 32 / out_last out 1: result stream
- cfg_we in 1 / cfg_sel in 1 (0=X, 1=Y) / cfg_addr in 3 / cfg_data in 32: coefficient write
- k_ap_start out 1 / k_ap_done in 1 / k_ap_ready in 1 / k_ap_idle in 1: kernel control
- img_ce0 in 1 / img_we0 in 1 / img_address0 in 10 / img_d0 in 32 / img_q0 out 32
- mask_img_ce0, mask_img_we0, mask_img_address0[10], mask_img_d0[32] in; mask_img_q0 out 32
- kernelDataX_ce0, _we0, _address0[3], _d0[32] in; kernelDataX_q0 out 32 (same set for kernelDataY)

Behaviour:
- Reset values: busy=0, in_ready=0, out_valid=0, out_last=0, out_data=0, k_ap_start=0, all *_q0=0, state=IDLE. RAM contents are not cleared; coefficient tables reset to 0.
- Memory model for all four kernel-facing ports:
  - Single port, read-first, 1-cycle latency: on ce0, q0 <= mem[addr] on the next edge.
  - If we0 is also high, mem[addr] <= d0 on that edge and q0 returns the old value.
  - q0 holds its value when ce0=0.
- Out-of-range img/mask addresses (>= NUM_PIX) read 0 and ignore writes.
- Kernel-port accesses take effect only in RUN; in other states they are ignored and q0 holds.
- IDLE:
  - in_ready=0.
  - A cfg_we write updates the selected table at cfg_addr; cfg writes outside IDLE are ignored.
  - go=1 -> LOAD with wr_cnt=0.
- LOAD:
  - in_ready=1.
  - Each in_valid&in_ready beat writes img[wr_cnt] and increments wr_cnt.
  - On the beat where wr_cnt==NUM_PIX-1: in_ready drops the next cycle, go to START.
- START:
  - k_ap_start=1, held until the cycle k_ap_ready=1 is sampled; k_ap_start=0 from the next cycle.
  - k_ap_done may assert in the same cycle as k_ap_ready; if so, go straight to DRAIN. Otherwise go to RUN.
- RUN: wait for a k_ap_done pulse -> DRAIN with rd_cnt=0.
- DRAIN:
  - Reads mask RAM through an internal port, separate from the kernel port (dual-port array).
  - Read latency 1; a 2-entry output FIFO absorbs that latency.
  - A read is issued only when FIFO occupancy plus reads in flight is < 2, so no data is lost under back-pressure.
  - out_valid = FIFO non-empty. out_data and out_last stay stable while out_valid & !out_ready.
  - out_last=1 with the word for address NUM_PIX-1.
  - After the out_last beat is accepted, go to IDLE.
  - Sustained out_ready=1 gives 1 word/cycle after a 2-cycle initial latency from DRAIN entry.
- go while busy is ignored.
- k_ap_done outside START/RUN is ignored.
- ap_rst mid-frame: return to IDLE the next edge with all outputs at reset values. The kernel must be reset by the same ap_rst.

Test Plan:
- Reset then idle: ap_rst 2 cycles -> busy=0, in_ready=0, out_valid=0, k_ap_start=0.
- Config + kernel read: write X[5]=0x11, Y[2]=0x22 in IDLE, run a frame, kernel reads X addr 5 -> kernelDataX_q0=0x11 one cycle after ce0. A cfg write during RUN leaves the table unchanged.
- Loopback frame (NUM_PIX=16): stream pixels 0..15, kernel model copies img[i]+1 to mask[i] -> out_data 1..16 in order, out_last only on 16, then state IDLE.
- Start handshake: k_ap_ready delayed 5 cycles -> k_ap_start high exactly 6 cycles, drops the cycle after ready. A done coincident with ready is accepted.
- Back-pressure: out_ready toggled 1,0,0,1 randomly -> no word dropped or duplicated, data stable while stalled, 16 words total.
- Read-first RAM: kernel writes mask[3]=0xAA with ce0&we0 where the old value was 0x5 -> q0=0x5 next cycle; a later read returns 0xAA.
- Reset mid-LOAD after 7 pixels -> IDLE the next cycle; a new go loads from address 0.
